// File: rtl/ifmap_pkg.sv
// ifmap_pkg: shared geometry, FSM encoding and packet field offsets for the ifmap spike buffer.
`default_nettype none
package ifmap_pkg;
  localparam int DEPTH_I  = 25;
  localparam int KERNEL   = 5;
  localparam int N_WIN    = DEPTH_I - KERNEL + 1;
  localparam int N_PKT    = N_WIN * KERNEL;
  localparam int MAP_BITS = DEPTH_I * DEPTH_I;

  localparam int MAP0_LSB = 0;
  localparam int MAP1_LSB = DEPTH_I;
  localparam int ROW_LSB  = 2 * DEPTH_I;
  localparam int WIN_LSB  = ROW_LSB + 5;
  localparam int HDR_W    = 5;

  typedef enum logic [1:0] {
    S_TS   = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_OUT  = 2'd3
  } state_e;
endpackage
`default_nettype wire

// File: rtl/ifmap_spike_mem.sv
// ifmap_spike_mem: two 25x25 binary spike maps in flops, single-bit write port,
// one combinational row read per map sharing a row index.
`default_nettype none
module ifmap_spike_mem
  import ifmap_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic                  wsel_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic                  wdata_i,
  input  logic [4:0]            row_i,
  output logic [DEPTH_I-1:0]    row0_o,
  output logic [DEPTH_I-1:0]    row1_o
);

  logic [MAP_BITS-1:0] map0_q;
  logic [MAP_BITS-1:0] map1_q;
  logic [9:0]          row_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      map0_q <= '0;
      map1_q <= '0;
    end else if (we_i) begin
      if (wsel_i) map1_q[waddr_i] <= wdata_i;
      else        map0_q[waddr_i] <= wdata_i;
    end
  end

  assign row_base = 10'(row_i) * 10'(DEPTH_I);
  assign row0_o   = map0_q[row_base +: DEPTH_I];
  assign row1_o   = map1_q[row_base +: DEPTH_I];

endmodule
`default_nettype wire

// File: rtl/ifmap_spike_buffer.sv
// ifmap_spike_buffer: loads two spike maps over ts/addr/din handshakes, then streams 5-row windows.
// Optional macro IFMAP_HDR_EN adds the row/window header in bits [59:50].
`default_nettype none
module ifmap_spike_buffer
  import ifmap_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int PACK_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ts_valid_i,
  output logic                  ts_ready_o,
  input  logic [1:0]            ts_data_i,
  input  logic                  addr_valid_i,
  output logic                  addr_ready_o,
  input  logic [ADDR_WIDTH-1:0] addr_data_i,
  input  logic                  din_valid_i,
  output logic                  din_ready_o,
  input  logic                  din_data_i,
  input  logic                  done_valid_i,
  output logic                  done_ready_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [PACK_WIDTH-1:0] out_data_o
);

  state_e                state_q, state_d;
  logic [1:0]            ts_q, ts_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [4:0]            r_q, r_d;
  logic [2:0]            k_q, k_d;
  logic                  out_valid_q, out_valid_d;
  logic [PACK_WIDTH-1:0] out_data_q, out_data_d;
  logic                  rdy_en_q;

  logic                  ts_fire, done_fire, addr_fire, din_fire, out_fire, last_pkt;
  logic                  mem_we;
  logic [4:0]            row_sel;
  logic [DEPTH_I-1:0]    row0, row1;
  logic [PACK_WIDTH-1:0] pack;

  // Load readies stay low for the first cycle out of reset.
  assign ts_ready_o   = rdy_en_q && (state_q == S_TS);
  assign done_ready_o = ts_ready_o && !ts_valid_i;
  assign addr_ready_o = (state_q == S_ADDR);
  assign din_ready_o  = (state_q == S_DATA);
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;

  assign ts_fire   = ts_valid_i && ts_ready_o;
  assign done_fire = done_valid_i && done_ready_o;
  assign addr_fire = addr_valid_i && addr_ready_o;
  assign din_fire  = din_valid_i && din_ready_o;
  assign out_fire  = out_valid_q && out_ready_i;
  assign last_pkt  = (r_q == 5'(N_WIN - 1)) && (k_q == 3'(KERNEL - 1));

  assign mem_we = din_fire && (ts_q == 2'd1 || ts_q == 2'd2)
                  && (addr_q < ADDR_WIDTH'(MAP_BITS));

  // Outside S_OUT the read points at row 0 so the first packet is ready on the done edge.
  assign row_sel = (state_q == S_OUT) ? (r_q + 5'(k_q)) : 5'd0;

  ifmap_spike_mem #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .wsel_i  (ts_q[1]),
    .waddr_i (addr_q),
    .wdata_i (din_data_i),
    .row_i   (row_sel),
    .row0_o  (row0),
    .row1_o  (row1)
  );

  always_comb begin
    pack = '0;
    pack[MAP0_LSB +: DEPTH_I] = row0;
    pack[MAP1_LSB +: DEPTH_I] = row1;
`ifdef IFMAP_HDR_EN
    pack[ROW_LSB +: HDR_W] = row_sel;
    pack[WIN_LSB +: HDR_W] = (state_q == S_OUT) ? r_q : 5'd0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    ts_d        = ts_q;
    addr_d      = addr_q;
    r_d         = r_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_TS: begin
        if (ts_fire) begin
          ts_d    = ts_data_i;
          state_d = S_ADDR;
        end else if (done_fire) begin
          state_d     = S_OUT;
          r_d         = '0;
          k_d         = '0;
          out_valid_d = 1'b1;
          out_data_d  = pack;
        end
      end
      S_ADDR: begin
        if (addr_fire) begin
          addr_d  = addr_data_i;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (din_fire) state_d = S_TS;
      end
      S_OUT: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          if (last_pkt) begin
            state_d = S_TS;
            r_d     = '0;
            k_d     = '0;
          end else if (k_q == 3'(KERNEL - 1)) begin
            k_d = '0;
            r_d = r_q + 5'd1;
          end else begin
            k_d = k_q + 3'd1;
          end
        end else if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = pack;
        end
      end
      default: state_d = S_TS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_TS;
      ts_q        <= '0;
      addr_q      <= '0;
      r_q         <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      addr_q      <= addr_d;
      r_q         <= r_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifmap_spike_buffer.sv
// tb_ifmap_spike_buffer: randomized load/stream bench with a queue scoreboard and a map model.
`default_nettype none
module tb_ifmap_spike_buffer;
  import ifmap_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ts_valid = 1'b0, ts_ready;
  logic [1:0]  ts_data = '0;
  logic        addr_valid = 1'b0, addr_ready;
  logic [9:0]  addr_data = '0;
  logic        din_valid = 1'b0, din_ready, din_data = 1'b0;
  logic        done_valid = 1'b0, done_ready;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] out_data;

  int          n_chk = 0;
  int          n_fail = 0;
  int          pkt_cnt = 0;
  bit          hold = 1'b0;
  logic [63:0] exp_q[$];
  logic [24:0] m0[25];
  logic [24:0] m1[25];

  always #5 clk = ~clk;

  ifmap_spike_buffer #(.ADDR_WIDTH(10), .PACK_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .ts_valid_i(ts_valid), .ts_ready_o(ts_ready), .ts_data_i(ts_data),
    .addr_valid_i(addr_valid), .addr_ready_o(addr_ready), .addr_data_i(addr_data),
    .din_valid_i(din_valid), .din_ready_o(din_ready), .din_data_i(din_data),
    .done_valid_i(done_valid), .done_ready_o(done_ready),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_pkt(input int r, input int k);
    logic [63:0] p;
    int i;
    i = r + k;
    p = '0;
    p[24:0]  = m0[i];
    p[49:25] = m1[i];
`ifdef IFMAP_HDR_EN
    p[54:50] = 5'(i);
    p[59:55] = 5'(r);
`endif
    return p;
  endfunction

  function automatic bit rdy(input int ch);
    case (ch)
      0: return ts_ready;
      1: return addr_ready;
      2: return din_ready;
      default: return done_ready;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 25; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    exp_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic xfer(input int ch, input logic [9:0] v);
    int n;
    n = 0;
    case (ch)
      0: begin ts_valid = 1'b1; ts_data = v[1:0]; end
      1: begin addr_valid = 1'b1; addr_data = v; end
      2: begin din_valid = 1'b1; din_data = v[0]; end
      default: done_valid = 1'b1;
    endcase
    forever begin
      @(negedge clk);
      if (rdy(ch)) break;
      n++;
      if (n > 500) begin
        n_chk++; n_fail++;
        $display("FAIL handshake_timeout ch%0d: got no ready expected ready", ch);
        break;
      end
    end
    @(posedge clk); #1;
    ts_valid = 1'b0; addr_valid = 1'b0; din_valid = 1'b0; done_valid = 1'b0;
  endtask

  task automatic write_px(input int t, input int a, input bit d);
    xfer(0, 10'(t));
    xfer(1, 10'(a));
    xfer(2, 10'(d));
    if ((t == 1 || t == 2) && a < 625) begin
      if (t == 1) m0[a / 25][a % 25] = d;
      else        m1[a / 25][a % 25] = d;
    end
  endtask

  task automatic start_stream();
    for (int r = 0; r < 21; r++)
      for (int k = 0; k < 5; k++)
        exp_q.push_back(exp_pkt(r, k));
    pkt_cnt = 0;
    xfer(3, '0);
  endtask

  task automatic wait_pkts(input int n);
    int c;
    c = 0;
    while (pkt_cnt < n && c < 3000) begin @(negedge clk); c++; end
    if (c >= 3000) begin
      n_chk++; n_fail++;
      $display("FAIL wait_pkts: got %0d packets expected %0d", pkt_cnt, n);
    end
  endtask

  task automatic finish_stream();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || !ts_ready) && c < 3000) begin @(negedge clk); c++; end
    check("stream_done", 64'(exp_q.size() == 0 && ts_ready), 64'd1);
    check("pkt_count", 64'(pkt_cnt), 64'd105);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = hold ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  // Monitor: pops expected packets on every accepted transfer, checks stall stability.
  initial begin
    logic [63:0] prev_d;
    bit          prev_stall;
    prev_d = '0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", out_data, prev_d);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL extra_pkt: got %h expected no packet", out_data);
          end else begin
            check($sformatf("pkt%0d", pkt_cnt), out_data, exp_q.pop_front());
          end
          pkt_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
      end
    end
  end

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ts_ready", 64'(ts_ready), 64'd0);
    check("rst_done_ready", 64'(done_ready), 64'd0);
    check("rst_addr_ready", 64'(addr_ready), 64'd0);
    check("rst_din_ready", 64'(din_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    @(negedge clk);
    check("idle_ts_ready", 64'(ts_ready), 64'd1);
    check("idle_done_ready", 64'(done_ready), 64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // ts and done together: only ts is taken
    ts_valid = 1'b1; ts_data = 2'd1; done_valid = 1'b1;
    @(negedge clk);
    check("both_done_ready", 64'(done_ready), 64'd0);
    check("both_ts_ready", 64'(ts_ready), 64'd1);
    @(posedge clk); #1;
    ts_valid = 1'b0; done_valid = 1'b0;
    xfer(1, 10'd5);
    xfer(2, 10'd1);
    m0[0][5] = 1'b1;

    // checkerboard on ts1, ts2 all zero
    for (int a = 0; a < 625; a++) write_px(1, a, (a % 2) == 0);
    check("model_row0", 64'(m0[0]), 64'h1555555);
    start_stream();
    finish_stream();

    do_reset();
    write_px(2, 624, 1'b1);
    start_stream();
    finish_stream();

    do_reset();
    write_px(3, 0, 1'b1);
    write_px(1, 700, 1'b1);
    start_stream();
    finish_stream();

    // random writes on retained maps, with a 10-cycle stall mid-stream
    for (int n = 0; n < 40; n++)
      write_px(int'($urandom_range(3)), int'($urandom_range(700)), 1'($urandom));
    start_stream();
    wait_pkts(30);
    @(posedge clk); #1;
    hold = 1'b1;
    repeat (10) @(posedge clk);
    #1 hold = 1'b0;
    finish_stream();

    // reset in the middle of packet 50
    for (int n = 0; n < 20; n++)
      write_px(int'($urandom_range(1, 2)), int'($urandom_range(624)), 1'b1);
    start_stream();
    wait_pkts(50);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", out_data, 64'd0);
    @(negedge clk);
    check("midrst_ts_ready", 64'(ts_ready), 64'd1);
    @(posedge clk); #1;
    start_stream();
    finish_stream();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
